// File: rtl/sb_param_ccff_pkg.sv
// sb_param_pkg: shared types and helpers for the parametrised corner switch block.
//   SEL_W     : select bits per routing mux (4-input muxes -> 2)
//   sel_e     : routing mux source encoding
//   state_e   : configuration load controller states
//   cfg_bits  : total configuration chain length for a channel width
package sb_param_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    SEL_GRID     = 2'd0,
    SEL_TWIST    = 2'd1,
    SEL_STRAIGHT = 2'd2,
    SEL_ZERO     = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    OVER = 2'd3
  } state_e;

  // Two sides (top, left), one mux per track, sw select bits per mux.
  function automatic int cfg_bits(input int w, input int sw = SEL_W);
    return 2 * w * sw;
  endfunction

endpackage

// File: rtl/sb_param_ccff_if.sv
// sb_param_ccff_if: routing bus of the corner switch block.
//   chany_top_in / chanx_left_in   : incoming channel tracks
//   top_grid_pin / left_grid_pin   : grid output pins feeding each side
//   chany_top_out / chanx_left_out : driven channel tracks
// Modports: master (environment side), slave (switch block side).
interface sb_param_ccff_if #(
  parameter int CHAN_WIDTH = 9
);
  logic [CHAN_WIDTH-1:0] chany_top_in;
  logic [CHAN_WIDTH-1:0] chanx_left_in;
  logic [CHAN_WIDTH-1:0] top_grid_pin;
  logic [CHAN_WIDTH-1:0] left_grid_pin;
  logic [CHAN_WIDTH-1:0] chany_top_out;
  logic [CHAN_WIDTH-1:0] chanx_left_out;

  modport master (
    output chany_top_in, chanx_left_in, top_grid_pin, left_grid_pin,
    input  chany_top_out, chanx_left_out
  );

  modport slave (
    input  chany_top_in, chanx_left_in, top_grid_pin, left_grid_pin,
    output chany_top_out, chanx_left_out
  );
endinterface

// File: rtl/sb_param_ccff_mux4.sv
// sb_route_mux4: one 4-input routing mux.
//   i_d   : candidate sources, index = select code (grid, twist, straight, zero)
//   i_sel : select code from the configuration
//   o_y   : routed track
module sb_route_mux4
  import sb_param_pkg::*;
(
  input  logic [3:0]       i_d,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_y
);
  always_comb begin
    o_y = 1'b0;
    case (sel_e'(i_sel))
      SEL_GRID:     o_y = i_d[0];
      SEL_TWIST:    o_y = i_d[1];
      SEL_STRAIGHT: o_y = i_d[2];
      SEL_ZERO:     o_y = 1'b0;
      default:      o_y = 1'b0;
    endcase
  end
endmodule

// File: rtl/sb_param_ccff.sv
// sb_param_ccff: parametrised corner switch block (top + left sides) configured
// through a serial scan chain, with a load controller reporting done/overflow.
// Ports:
//   prog_clk, pReset (async, active low)
//   ccff_head, ccff_shift_en, ccff_restart : chain data and control
//   cfg_commit : copy chain into active config (shadow build only)
//   ccff_tail, cfg_done, cfg_overflow      : chain out and load status
//   bus (sb_param_ccff_if.slave)           : routing tracks and grid pins
// Build option: SB_CFG_SHADOW_EN adds an active-config shadow register so the
// routing only changes on a commit in DONE; otherwise the muxes read the chain.
module sb_param_ccff
  import sb_param_pkg::*;
#(
  parameter int CHAN_WIDTH = 9,
  parameter int SEL_W      = sb_param_pkg::SEL_W
) (
  input  logic prog_clk,
  input  logic pReset,
  input  logic ccff_head,
  input  logic ccff_shift_en,
  input  logic ccff_restart,
  input  logic cfg_commit,
  output logic ccff_tail,
  output logic cfg_done,
  output logic cfg_overflow,
  sb_param_ccff_if.slave bus
);
  localparam int CFG_BITS = cfg_bits(CHAN_WIDTH, SEL_W);
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  logic [CFG_BITS-1:0] r_cfg;
  logic [CFG_BITS-1:0] w_sel_src;
  state_e              r_state, w_nxt_state;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;

  // Chain shifts independently of the controller, including during restart.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset)            r_cfg <= '0;
    else if (ccff_shift_en) r_cfg <= {r_cfg[CFG_BITS-2:0], ccff_head};
  end

  assign ccff_tail = r_cfg[CFG_BITS-1];

`ifdef SB_CFG_SHADOW_EN
  logic [CFG_BITS-1:0] r_act;
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset)                              r_act <= '0;
    else if (cfg_commit && r_state == DONE)   r_act <= r_cfg;
  end
  assign w_sel_src = r_act;
`else
  logic w_unused_commit;
  assign w_unused_commit = cfg_commit;
  assign w_sel_src       = r_cfg;
`endif

  // Controller: state register
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Controller: next state. Restart wins over a coincident shift.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    if (ccff_restart) begin
      w_nxt_state = IDLE;
      w_nxt_cnt   = '0;
    end else if (ccff_shift_en) begin
      case (r_state)
        IDLE: begin
          w_nxt_cnt   = CNT_W'(1);
          w_nxt_state = (CFG_BITS == 1) ? DONE : LOAD;
        end
        LOAD: begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
          if (r_cnt + CNT_W'(1) == CNT_W'(CFG_BITS)) w_nxt_state = DONE;
        end
        DONE: begin
          w_nxt_cnt   = CNT_W'(CFG_BITS + 1);
          w_nxt_state = OVER;
        end
        OVER: w_nxt_cnt = CNT_W'(CFG_BITS + 1);
        default: begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Controller: outputs. OVER is only left via restart/reset, so the flag is sticky.
  always_comb begin
    cfg_done     = (r_state == DONE);
    cfg_overflow = (r_state == OVER);
  end

  // Routing: mux j < W drives top track j, otherwise left track j-W.
  logic [2*CHAN_WIDTH-1:0] w_route;
  for (genvar j = 0; j < 2*CHAN_WIDTH; j++) begin : g_mux
    localparam int I  = j % CHAN_WIDTH;
    localparam int TW = (CHAN_WIDTH - I) % CHAN_WIDTH;
    logic [3:0] w_d;
    if (j < CHAN_WIDTH) begin : g_top
      assign w_d = {1'b0, bus.chanx_left_in[I], bus.chanx_left_in[TW], bus.top_grid_pin[I]};
    end else begin : g_left
      assign w_d = {1'b0, bus.chany_top_in[I], bus.chany_top_in[TW], bus.left_grid_pin[I]};
    end
    sb_route_mux4 u_mux (
      .i_d  (w_d),
      .i_sel(w_sel_src[j*SEL_W +: SEL_W]),
      .o_y  (w_route[j])
    );
  end

  assign bus.chany_top_out  = w_route[CHAN_WIDTH-1:0];
  assign bus.chanx_left_out = w_route[2*CHAN_WIDTH-1:CHAN_WIDTH];

endmodule

// File: tb/tb_sb_param_ccff.sv
// tb_sb_param_ccff: directed, table-driven bench for sb_param_ccff (W=9, 36-bit chain).
// Compile with +define+SB_CFG_SHADOW_EN to exercise the shadow-register build.
module tb_sb_param_ccff;
  localparam int W  = 9;
  localparam int CB = 36;

  logic prog_clk = 1'b0;
  logic pReset, ccff_head, ccff_shift_en, ccff_restart, cfg_commit;
  logic ccff_tail, cfg_done, cfg_overflow;

  sb_param_ccff_if #(.CHAN_WIDTH(W)) bus ();

  sb_param_ccff #(.CHAN_WIDTH(W), .SEL_W(2)) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_restart (ccff_restart),
    .cfg_commit   (cfg_commit),
    .ccff_tail    (ccff_tail),
    .cfg_done     (cfg_done),
    .cfg_overflow (cfg_overflow),
    .bus          (bus)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [W-1:0] top_in, left_in, top_gp, left_gp, exp_top, exp_left;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [CB-1:0] act, input logic [CB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    bus.chany_top_in  = v.top_in;
    bus.chanx_left_in = v.left_in;
    bus.top_grid_pin  = v.top_gp;
    bus.left_grid_pin = v.left_gp;
  endtask

  task automatic shift1(input logic b);
    @(negedge prog_clk);
    ccff_head = b; ccff_shift_en = 1'b1;
    @(posedge prog_clk); #1;
    ccff_shift_en = 1'b0;
  endtask

  // Shift v[hi] first down to v[lo].
  task automatic shift_range(input logic [CB-1:0] v, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) shift1(v[k]);
  endtask

  task automatic pulse_commit();
    @(negedge prog_clk); cfg_commit = 1'b1;
    @(posedge prog_clk); #1; cfg_commit = 1'b0;
  endtask

  task automatic pulse_restart(input logic with_shift, input logic b);
    @(negedge prog_clk);
    ccff_restart = 1'b1; ccff_shift_en = with_shift; ccff_head = b;
    @(posedge prog_clk); #1;
    ccff_restart = 1'b0; ccff_shift_en = 1'b0;
  endtask

  vec_t rst_tab[4];
  vec_t a_tab[5];
  logic [CB-1:0] cfg_a, cfg_st;

  initial begin
    // Grid-only (reset) vectors: outputs must equal grid pins.
    rst_tab[0] = '{9'h0AA, 9'h155, 9'h1A5, 9'h0F0, 9'h1A5, 9'h0F0};
    rst_tab[1] = '{9'h1FF, 9'h1FF, 9'h000, 9'h1FF, 9'h000, 9'h1FF};
    rst_tab[2] = '{9'h000, 9'h000, 9'h155, 9'h0AA, 9'h155, 9'h0AA};
    rst_tab[3] = '{9'h123, 9'h0C3, 9'h1FF, 9'h000, 9'h1FF, 9'h000};
    // Top twisted (left_in[(9-i)%9]), left straight (top_in[i]).
    a_tab[0] = '{9'h0AA, 9'h100, 9'h1A5, 9'h0F0, 9'h002, 9'h0AA};
    a_tab[1] = '{9'h155, 9'h001, 9'h1A5, 9'h0F0, 9'h001, 9'h155};
    a_tab[2] = '{9'h000, 9'h003, 9'h1FF, 9'h1FF, 9'h101, 9'h000};
    a_tab[3] = '{9'h1FF, 9'h1FF, 9'h000, 9'h000, 9'h1FF, 9'h1FF};
    a_tab[4] = '{9'h123, 9'h00C, 9'h1A5, 9'h0F0, 9'h0C0, 9'h123};
    for (int j = 0; j < 2*W; j++) begin
      cfg_a[j*2 +: 2]  = (j < W) ? 2'd1 : 2'd2;
      cfg_st[j*2 +: 2] = 2'd2;
    end

    pReset = 1'b0; ccff_head = 1'b0; ccff_shift_en = 1'b0;
    ccff_restart = 1'b0; cfg_commit = 1'b0;
    set_in(rst_tab[0]);
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk); pReset = 1'b1;
    @(posedge prog_clk); #1;

    // Reset state
    chk("rst_done", cfg_done, 0);
    chk("rst_ovf", cfg_overflow, 0);
    chk("rst_tail", ccff_tail, 0);
    for (int i = 0; i < 4; i++) begin
      set_in(rst_tab[i]); #1;
      chk($sformatf("rst_top[%0d]", i), bus.chany_top_out, rst_tab[i].exp_top);
      chk($sformatf("rst_left[%0d]", i), bus.chanx_left_out, rst_tab[i].exp_left);
    end

    // Load config A, done exactly on the 36th edge; first bit on tail.
    shift_range(cfg_a, CB-1, 1);
    chk("a_done_35", cfg_done, 0);
    shift_range(cfg_a, 0, 0);
    chk("a_done_36", cfg_done, 1);
    chk("a_tail_36", ccff_tail, cfg_a[CB-1]);
    pulse_commit();
    chk("a_done_after_commit", cfg_done, 1);
    for (int i = 0; i < 5; i++) begin
      set_in(a_tab[i]); #1;
      chk($sformatf("a_top[%0d]", i), bus.chany_top_out, a_tab[i].exp_top);
      chk($sformatf("a_left[%0d]", i), bus.chanx_left_out, a_tab[i].exp_left);
    end

    // Overflow and restart
    shift1(1'b0);
    chk("ovf_done", cfg_done, 0);
    chk("ovf_flag", cfg_overflow, 1);
    chk("ovf_tail", ccff_tail, cfg_a[CB-2]);
    shift1(1'b0);
    chk("ovf_sticky", cfg_overflow, 1);
    pulse_restart(1'b0, 1'b0);
    chk("rs_done", cfg_done, 0);
    chk("rs_ovf", cfg_overflow, 0);

    // Reload A, then reset mid-load: async abort, grid outputs without a clock.
    pReset = 1'b0; #1; pReset = 1'b1;
    shift_range(cfg_a, CB-1, 0);
    pulse_commit();
    set_in(a_tab[0]);
    shift_range(cfg_a, CB-1, CB-20);
    @(negedge prog_clk); #2;
    pReset = 1'b0; #1;
    chk("mid_rst_top", bus.chany_top_out, a_tab[0].top_gp);
    chk("mid_rst_left", bus.chanx_left_out, a_tab[0].left_gp);
    chk("mid_rst_done", cfg_done, 0);
    chk("mid_rst_ovf", cfg_overflow, 0);
    chk("mid_rst_tail", ccff_tail, 0);
    @(negedge prog_clk); pReset = 1'b1;
    shift_range(cfg_a, CB-1, 0);
    chk("reload_done", cfg_done, 1);

    // All muxes forced to zero
    pulse_restart(1'b0, 1'b0);
    shift_range({CB{1'b1}}, CB-1, 0);
    chk("zero_done", cfg_done, 1);
    pulse_commit();
    set_in('{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h0, 9'h0}); #1;
    chk("zero_top", bus.chany_top_out, 0);
    chk("zero_left", bus.chanx_left_out, 0);

    // Restart with a concurrent shift: chain moves, counter ends at 0.
    pulse_restart(1'b1, 1'b0);
    chk("rsh_done", cfg_done, 0);
    chk("rsh_ovf", cfg_overflow, 0);
`ifndef SB_CFG_SHADOW_EN
    chk("rsh_top", bus.chany_top_out, 9'h001);
    chk("rsh_left", bus.chanx_left_out, 9'h000);
`endif
    shift_range({CB{1'b1}}, CB-1, 1);
    chk("rsh_done_35", cfg_done, 0);
    shift1(1'b1);
    chk("rsh_done_36", cfg_done, 1);

`ifdef SB_CFG_SHADOW_EN
    // Shadow: routing frozen until a commit in DONE.
    @(negedge prog_clk); pReset = 1'b0; #1; pReset = 1'b1;
    set_in(a_tab[4]);
    shift_range(cfg_st, CB-1, CB-20);
    chk("sh_load_top", bus.chany_top_out, a_tab[4].top_gp);
    pulse_commit();
    chk("sh_commit_load_top", bus.chany_top_out, a_tab[4].top_gp);
    chk("sh_commit_load_left", bus.chanx_left_out, a_tab[4].left_gp);
    shift_range(cfg_st, CB-21, 0);
    chk("sh_done", cfg_done, 1);
    chk("sh_pre_top", bus.chany_top_out, a_tab[4].top_gp);
    pulse_commit();
    chk("sh_st_top", bus.chany_top_out, a_tab[4].left_in);
    chk("sh_st_left", bus.chanx_left_out, a_tab[4].top_in);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sb_param_ccff.md
Name: sb_param_ccff

Overview:
- Parametrised successor to the fixed 2-input switch blocks for corner SBs with a top side and a left side.
- Routes CHAN_WIDTH tracks per side through 4-input routing muxes, one per output track.
- Configured by a scan-style configuration chain (ccff_head to ccff_tail).
- A load controller counts shifted bits and reports config-done and overflow.
- Optional shadow register allows glitch-free reconfiguration.

Parameters:
- CHAN_WIDTH, 9, tracks per side (≥2).
- SEL_W, 2, select bits per mux; fixed at 2 for 4-input muxes, exposed for the package.
- CFG_BITS, 2*CHAN_WIDTH*SEL_W, derived localparam: total chain length.

Ports:
- prog_clk  in  1  configuration/state clock.
- pReset  in  1  asynchronous, active-low reset.
- ccff_head  in  1  serial config data in.
- ccff_shift_en  in  1  shift chain one bit this cycle.
- ccff_restart  in  1  sync pulse: clear counter/state, keep chain contents.
- cfg_commit  in  1  copy chain into active config (SB_CFG_SHADOW_EN only).
- chany_top_in  in  CHAN_WIDTH  top channel incoming tracks.
- chanx_left_in  in  CHAN_WIDTH  left channel incoming tracks.
- top_grid_pin  in  CHAN_WIDTH  grid output pins feeding the top tracks.
- left_grid_pin  in  CHAN_WIDTH  grid output pins feeding the left tracks.
- chany_top_out  out  CHAN_WIDTH  top channel driven tracks.
- chanx_left_out  out  CHAN_WIDTH  left channel driven tracks.
- ccff_tail  out  1  serial config data out (chain MSB).
- cfg_done  out  1  exactly CFG_BITS shifts completed.
- cfg_overflow  out  1  sticky: more than CFG_BITS shifts.

Behaviour:
- Chain register cfg[CFG_BITS-1:0].
  - On a prog_clk edge with ccff_shift_en=1: cfg <= {cfg[CFG_BITS-2:0], ccff_head}.
  - ccff_tail = cfg[CFG_BITS-1], registered output.
  - The first bit shifted in lands in cfg[CFG_BITS-1] after CFG_BITS shifts.
- Mux indexing:
  - j = 0..W-1 is top track j; j = W..2W-1 is left track j-W.
  - Mux j select = sel_src[j*SEL_W +: SEL_W], where sel_src = cfg (no shadow) or act (shadow).
- Top track i select decode:
  - 0 = top_grid_pin[i]
  - 1 = chanx_left_in[(W-i) mod W] (twisted)
  - 2 = chanx_left_in[i] (straight)
  - 3 = 1'b0
- Left track i select decode: same scheme using left_grid_pin and chany_top_in.
- The data path is purely combinational. A config change is visible immediately after the prog_clk edge that updates sel_src.
- Reset (pReset=0, asynchronous):
  - cfg = 0, act = 0, counter = 0, state IDLE.
  - cfg_done = 0, cfg_overflow = 0, ccff_tail = 0.
  - All outputs follow their grid pins.
- Counter cnt, width clog2(CFG_BITS+2), saturating at CFG_BITS+1.
- FSM states (registered):
  - IDLE: cnt=0. A shift moves to LOAD with cnt=1; if CFG_BITS=1, go straight to DONE.
  - LOAD: a shift increments cnt; when cnt reaches CFG_BITS, go to DONE.
  - DONE: cfg_done=1. A further shift goes to OVER.
  - OVER: cfg_done=0, cfg_overflow=1 (sticky). Shifts keep moving the chain; cnt stays saturated.
- ccff_restart=1 moves to IDLE and clears cnt, cfg_done and cfg_overflow the next edge.
  - Restart has priority over a simultaneous shift: the chain still shifts, but the counter ends at 0.
- Reset asserted mid-load aborts immediately. No partial state is retained.
- Outputs depend only on sel_src. Without shadow, outputs change during shifting; this is by design.

Optional Feature:
- Macro SB_CFG_SHADOW_EN.
- Defined:
  - act[CFG_BITS-1:0] drives the muxes.
  - cfg_commit=1 while in DONE loads act <= cfg on that edge.
  - cfg_commit in IDLE/LOAD/OVER is ignored.
  - Routing never changes during shifting.
- Undefined:
  - Muxes read cfg directly.
  - cfg_commit is an unused input; no act register exists.

Decomposition:
- Package sb_param_pkg:
  - SEL_W.
  - sel enum: SEL_GRID=0, SEL_TWIST=1, SEL_STRAIGHT=2, SEL_ZERO=3.
  - state enum: IDLE, LOAD, DONE, OVER.
  - Function cfg_bits(W).
- One sub-module, sb_route_mux4: 4-input mux, 2-bit select. Instantiated 2*CHAN_WIDTH times via generate.
- The chain, counter and FSM live in the top module.

Test Plan:
- Reset release, W=9, top_grid_pin=9'h1A5, left_grid_pin=9'h0F0 -> chany_top_out=9'h1A5, chanx_left_out=9'h0F0, cfg_done=0, cfg_overflow=0.
- Shift 36 bits so every top mux=1 and every left mux=2; drive chanx_left_in bit 8 only -> chany_top_out[1]=1, all other top bits 0. cfg_done=1 after exactly the 36th shift edge.
- Shift a 37th bit -> cfg_done=0, cfg_overflow=1. The first bit shifted appears on ccff_tail after the 36th shift edge. Then ccff_restart -> both flags 0, state IDLE.
- Assert pReset after 20 shifts -> all flags 0, outputs equal grid pins immediately without a clock. A full 36-bit reload after release -> cfg_done=1.
- Program all muxes to 3 -> both outputs 0 regardless of inputs. Restart and shift concurrently -> cnt=0, chain advanced by 1.
- SB_CFG_SHADOW_EN:
  - Load 36 bits selecting straight -> outputs unchanged (still grid) until cfg_commit in DONE, then chany_top_out==chanx_left_in.
  - cfg_commit in LOAD -> no change.
